// File: rtl/debug_pkg.sv
// Shared encodings for the debug run-control block.
package debug_pkg;

    localparam int unsigned DEFAULT_NUM_BP = 4;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_RUN     = 3'd1,
        OP_HALT    = 3'd2,
        OP_STEP    = 3'd3,
        OP_SET_BP  = 3'd4,
        OP_CLR_BP  = 3'd5,
        OP_CLR_CNT = 3'd6,
        OP_RSVD    = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } run_state_e;

endpackage

// File: rtl/bp_compare.sv
// PC breakpoint comparator bank: full 32-bit compare per enabled slot,
// lowest matching slot index reported.
module bp_compare
    import debug_pkg::*;
#(
    parameter int unsigned NUM_BP = DEFAULT_NUM_BP
) (
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [NUM_BP*32-1:0] bp_addr,
    input  logic [31:0]          pc,
    output logic                 match,
    output logic [2:0]           match_idx
);

    // Priority scan: the first hit found from slot 0 upward is kept.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!match && bp_en[i] && (bp_addr[i*32 +: 32] == pc)) begin
                match     = 1'b1;
                match_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run control: run/halt/step FSM, PC breakpoint slots, executed
// cycle counter and halt generation for the CPU.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned NUM_BP    = DEFAULT_NUM_BP,
    parameter int unsigned RESET_RUN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,
    input  logic [31:0] current_pc,
    output logic        halt,
    output logic [1:0]  run_state,
    output logic        bp_hit,
    output logic [2:0]  bp_hit_idx,
    output logic [31:0] instr_cnt
);

    localparam run_state_e RST_STATE = (RESET_RUN != 0) ? ST_RUNNING : ST_HALTED;

    run_state_e          state_q, state_d;
    logic                skip_q, skip_d;
    logic [NUM_BP-1:0]   en_q;
    logic [NUM_BP*32-1:0] addr_q;
    logic [31:0]         cnt_q;
    logic                match;
    logic [2:0]          match_idx;
    logic                accept;
    logic                bp_stop;

    bp_compare #(.NUM_BP(NUM_BP)) u_cmp (
        .bp_en     (en_q),
        .bp_addr   (addr_q),
        .pc        (current_pc),
        .match     (match),
        .match_idx (match_idx)
    );

    assign cmd_ready = (state_q != ST_STEP);
    assign accept    = cmd_valid && cmd_ready;
    assign bp_stop   = (state_q == ST_RUNNING) && match && !skip_q;
    assign run_state = state_q;
    assign instr_cnt = cnt_q;

    // State register and skip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            skip_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state and halt decode.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        halt    = 1'b1;
        case (state_q)
            ST_HALTED: begin
                halt = 1'b1;
                if (accept && (cmd_op == OP_RUN)) begin
                    state_d = ST_RUNNING;
                    skip_d  = 1'b1;
                end else if (accept && (cmd_op == OP_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUNNING: begin
                halt   = bp_stop;
                skip_d = 1'b0;
                if (bp_stop || (accept && (cmd_op == OP_HALT))) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                halt    = 1'b0;
                state_d = ST_HALTED;
            end
            default: begin
                halt    = 1'b1;
                state_d = ST_HALTED;
            end
        endcase
    end

    // Breakpoint slot registers; out-of-range slot indices match no slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            addr_q <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (cmd_idx == 3'(i)) begin
                    if (cmd_op == OP_SET_BP) begin
                        addr_q[i*32 +: 32] <= cmd_arg;
                        en_q[i]            <= 1'b1;
                    end else if (cmd_op == OP_CLR_BP) begin
                        en_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Breakpoint hit pulse and held slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit     <= 1'b0;
            bp_hit_idx <= '0;
        end else begin
            bp_hit <= bp_stop;
            if (bp_stop) begin
                bp_hit_idx <= match_idx;
            end
        end
    end

    // Executed-cycle counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && (cmd_op == OP_CLR_CNT)) begin
            cnt_q <= '0;
        end else if (!halt) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule
